// File: rtl/gpio_irq_ctrl_pkg.sv
// gpio_pkg: shared types and sizing helpers for the gpio interrupt controller.
// The controller state encoding, the source-id width calculation and the
// index of the group/all-condition interrupt source are defined here.
package gpio_pkg;

  // Controller state: waiting for an eligible source, or holding one for the CPU.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } irq_state_t;

  // Default pin count; the group source sits one past the last pin.
  localparam int GPIO_IRQ_WIDTH_DEFAULT = 8;
  localparam int GPIO_IRQ_SRC_GROUP     = GPIO_IRQ_WIDTH_DEFAULT;

  // Width of a source index covering sources 0..width (inclusive).
  function automatic int gpio_idw(input int width);
    int n;
    n = width + 1;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Index of the group source for a given pin count.
  function automatic int gpio_src_group(input int width);
    return width;
  endfunction

endpackage

// File: rtl/gpio_irq_ctrl_rr_pick.sv
// gpio_rr_pick: combinational round-robin picker.
// Returns the first set request at or after ptr, wrapping from N-1 to 0.
// ptr is expected to be in the range 0..N-1.
module gpio_rr_pick #(
  parameter int N  = 9,
  parameter int PW = 4
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [2*N-1:0] dbl_s;
  logic [N-1:0]   rot_s;
  logic [PW:0]    sum_s;
  logic [PW:0]    idx_s;

  // Rotate the requests so bit 0 is the ptr position, then take the lowest set bit.
  always_comb begin
    dbl_s   = {req, req} >> ptr;
    rot_s   = dbl_s[N-1:0];
    gnt_idx = '0;
    gnt_any = 1'b0;
    sum_s   = '0;
    idx_s   = '0;
    for (int k = 0; k < N; k++) begin
      sum_s   = {1'b0, ptr} + (PW+1)'(k);
      idx_s   = (sum_s >= (PW+1)'(N)) ? (sum_s - (PW+1)'(N)) : sum_s;
      gnt_idx = (rot_s[k] && !gnt_any) ? idx_s[PW-1:0] : gnt_idx;
      gnt_any = gnt_any | rot_s[k];
    end
  end

endmodule

// File: rtl/gpio_irq_ctrl.sv
// gpio_irq_ctrl: round-robin interrupt collector between gpio and the CPU.
// Accepts one eligible gpio interrupt at a time (one-cycle ir_ready pulse),
// presents it on irq_valid/irq_id until the CPU acknowledges, and counts
// completed acknowledges.
// Optional feature macro: GPIO_IRQ_GROUP_PRIO_EN -- when defined, the group
// source (index WIDTH) always wins and round-robin only covers the pins.
module gpio_irq_ctrl
  import gpio_pkg::*;
#(
  parameter  int WIDTH = GPIO_IRQ_WIDTH_DEFAULT,
  parameter  int CNT_W = 16,
  localparam int IDW   = gpio_idw(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH:0]   ir_valid,
  output logic [WIDTH:0]   ir_ready,
  input  logic [WIDTH:0]   enable,
  output logic             irq_valid,
  input  logic             irq_ready,
  output logic [IDW-1:0]   irq_id,
  output logic [CNT_W-1:0] irq_count
);

  localparam int NSRC = WIDTH + 1;
`ifdef GPIO_IRQ_GROUP_PRIO_EN
  localparam int RR_N = WIDTH;
`else
  localparam int RR_N = NSRC;
`endif
  localparam logic [IDW-1:0] GRP_ID  = IDW'(gpio_src_group(WIDTH));
  localparam logic [IDW-1:0] LAST_RR = IDW'(RR_N - 1);

  irq_state_t       state_r;
  logic [NSRC-1:0]  ir_ready_r;
  logic             irq_valid_r;
  logic [IDW-1:0]   irq_id_r;
  logic [CNT_W-1:0] irq_count_r;
  logic [IDW-1:0]   ptr_r;

  logic [NSRC-1:0]  eligible_s;
  logic [IDW-1:0]   rr_idx_s;
  logic             rr_any_s;
  logic [IDW-1:0]   gnt_idx_s;
  logic             gnt_any_s;
  logic [NSRC-1:0]  gnt_onehot_s;
  logic [IDW-1:0]   ptr_next_s;

  assign eligible_s = ir_valid & enable;

  gpio_rr_pick #(
    .N  (RR_N),
    .PW (IDW)
  ) u_rr_pick (
    .req     (eligible_s[RR_N-1:0]),
    .ptr     (ptr_r),
    .gnt_idx (rr_idx_s),
    .gnt_any (rr_any_s)
  );

  // Final grant: round-robin result, optionally overridden by the group source.
  always_comb begin
    gnt_idx_s = rr_idx_s;
    gnt_any_s = rr_any_s;
`ifdef GPIO_IRQ_GROUP_PRIO_EN
    if (eligible_s[WIDTH]) begin
      gnt_idx_s = GRP_ID;
      gnt_any_s = 1'b1;
    end else begin
      gnt_idx_s = rr_idx_s;
      gnt_any_s = rr_any_s;
    end
`endif
    gnt_onehot_s = {{(NSRC-1){1'b0}}, 1'b1} << gnt_idx_s;
  end

  // Pointer after serving irq_id_r: one past the served source, wrapping.
  always_comb begin
    ptr_next_s = ptr_r;
`ifdef GPIO_IRQ_GROUP_PRIO_EN
    if (irq_id_r == GRP_ID) begin
      ptr_next_s = ptr_r;
    end else if (irq_id_r == LAST_RR) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = irq_id_r + IDW'(1);
    end
`else
    if (irq_id_r == LAST_RR) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = irq_id_r + IDW'(1);
    end
`endif
  end

  // Controller FSM: grant in IDLE, hold for the CPU handshake in HOLD.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      ir_ready_r  <= '0;
      irq_valid_r <= 1'b0;
      irq_id_r    <= '0;
      irq_count_r <= '0;
      ptr_r       <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (gnt_any_s) begin
            irq_id_r    <= gnt_idx_s;
            irq_valid_r <= 1'b1;
            ir_ready_r  <= gnt_onehot_s;
            state_r     <= ST_HOLD;
          end else begin
            ir_ready_r  <= '0;
          end
        end
        ST_HOLD: begin
          // The gpio accept pulse lasts only the first HOLD cycle.
          ir_ready_r <= '0;
          if (irq_ready) begin
            irq_valid_r <= 1'b0;
            irq_count_r <= irq_count_r + CNT_W'(1);
            ptr_r       <= ptr_next_s;
            state_r     <= ST_IDLE;
          end else begin
            irq_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          ir_ready_r  <= '0;
          irq_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign ir_ready  = ir_ready_r;
  assign irq_valid = irq_valid_r;
  assign irq_id    = irq_id_r;
  assign irq_count = irq_count_r;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// tb_gpio_irq_ctrl: directed, table-driven bench for gpio_irq_ctrl (WIDTH=8).
// A second instance with a 4-bit counter exercises counter wrap-around.
module tb_gpio_irq_ctrl;

  logic        clock;
  logic        reset;
  logic [8:0]  ir_valid;
  logic [8:0]  ir_ready;
  logic [8:0]  enable;
  logic        irq_valid;
  logic        irq_ready;
  logic [3:0]  irq_id;
  logic [15:0] irq_count;

  logic [8:0]  w_ir_valid;
  logic [8:0]  w_ir_ready;
  logic        w_irq_valid;
  logic [3:0]  w_irq_id;
  logic [3:0]  w_irq_count;

  int n_tests = 0;
  int n_fail  = 0;

  gpio_irq_ctrl #(.WIDTH(8), .CNT_W(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .enable    (enable),
    .irq_valid (irq_valid),
    .irq_ready (irq_ready),
    .irq_id    (irq_id),
    .irq_count (irq_count)
  );

  gpio_irq_ctrl #(.WIDTH(8), .CNT_W(4)) dut_wrap (
    .clock     (clock),
    .reset     (reset),
    .ir_valid  (w_ir_valid),
    .ir_ready  (w_ir_ready),
    .enable    (9'h1FF),
    .irq_valid (w_irq_valid),
    .irq_ready (1'b1),
    .irq_id    (w_irq_id),
    .irq_count (w_irq_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [8:0]  iv;
    logic [8:0]  en;
    logic        rdy;
    int          reps;
    logic        exp_valid;
    logic [3:0]  exp_id;
    logic [8:0]  exp_ready;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [10];

  logic [3:0] got_ids   [8];
  logic [8:0] got_ready [8];
  int         got_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    ir_valid   = 9'h000;
    irq_ready  = 1'b0;
    w_ir_valid = 9'h000;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // Emulates gpio: pending bits are cleared on accept unless rearm keeps them raised.
  task automatic collect(input logic [8:0] pend_init, input logic rearm, input int n);
    logic [8:0] pend;
    pend      = pend_init;
    got_n     = 0;
    irq_ready = 1'b1;
    for (int c = 0; c < 100 && got_n < n; c++) begin
      ir_valid = pend;
      @(posedge clock);
      #1;
      if (ir_ready != 9'h000) begin
        got_ids[got_n]   = irq_id;
        got_ready[got_n] = ir_ready;
        if (!rearm) pend = pend & ~ir_ready;
        got_n++;
      end
    end
    irq_ready = 1'b0;
    ir_valid  = 9'h000;
    chk("grant_timeout", 32'(got_n), 32'(n));
  endtask

  logic [3:0] rr_exp [8];
  logic [3:0] grp_exp [2];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    enable = 9'h1FF;
    do_reset();
    chk("reset_valid", 32'(irq_valid), 32'd0);
    chk("reset_ready", 32'(ir_ready), 32'd0);
    chk("reset_id",    32'(irq_id),   32'd0);
    chk("reset_count", 32'(irq_count), 32'd0);

    // Single source, mask, earliest ack, enable change during HOLD.
    vecs[0] = '{9'h008, 9'h1FF, 1'b0, 1,  1'b1, 4'd3, 9'h008, 16'd0};
    vecs[1] = '{9'h000, 9'h1FF, 1'b0, 1,  1'b1, 4'd3, 9'h000, 16'd0};
    vecs[2] = '{9'h000, 9'h1FF, 1'b1, 1,  1'b0, 4'd3, 9'h000, 16'd1};
    vecs[3] = '{9'h000, 9'h1FF, 1'b1, 2,  1'b0, 4'd3, 9'h000, 16'd1};
    vecs[4] = '{9'h004, 9'h1FB, 1'b0, 20, 1'b0, 4'd3, 9'h000, 16'd1};
    vecs[5] = '{9'h004, 9'h1FF, 1'b0, 1,  1'b1, 4'd2, 9'h004, 16'd1};
    vecs[6] = '{9'h000, 9'h1FF, 1'b1, 1,  1'b0, 4'd2, 9'h000, 16'd2};
    vecs[7] = '{9'h040, 9'h1FF, 1'b0, 1,  1'b1, 4'd6, 9'h040, 16'd2};
    vecs[8] = '{9'h000, 9'h000, 1'b0, 1,  1'b1, 4'd6, 9'h000, 16'd2};
    vecs[9] = '{9'h000, 9'h000, 1'b1, 1,  1'b0, 4'd6, 9'h000, 16'd3};

    for (int v = 0; v < 10; v++) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        ir_valid  = vecs[v].iv;
        enable    = vecs[v].en;
        irq_ready = vecs[v].rdy;
        @(posedge clock);
        #1;
        chk($sformatf("vec%0d_valid", v), 32'(irq_valid), 32'(vecs[v].exp_valid));
        chk($sformatf("vec%0d_id", v),    32'(irq_id),    32'(vecs[v].exp_id));
        chk($sformatf("vec%0d_ready", v), 32'(ir_ready),  32'(vecs[v].exp_ready));
        chk($sformatf("vec%0d_count", v), 32'(irq_count), 32'(vecs[v].exp_cnt));
      end
    end
    enable = 9'h1FF;

    // Round-robin over sources 1,5,7 kept pending; after 1,5 the pointer is 6.
    do_reset();
    rr_exp = '{4'd1, 4'd5, 4'd7, 4'd1, 4'd5, 4'd7, 4'd1, 4'd5};
    collect(9'h0A2, 1'b1, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rr_id%0d", i), 32'(got_ids[i]), 32'(rr_exp[i]));
      chk($sformatf("rr_onehot%0d", i), 32'(got_ready[i]), 32'(9'h001) << rr_exp[i]);
    end

    // DUT is now holding source 5 with count 7; reset mid-HOLD clears outputs at once.
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_valid", 32'(irq_valid), 32'd0);
    chk("async_rst_ready", 32'(ir_ready),  32'd0);
    chk("async_rst_id",    32'(irq_id),    32'd0);
    chk("async_rst_count", 32'(irq_count), 32'd0);
    reset = 1'b1;

    // Stall: CPU holds off for 10 cycles with more sources pending.
    do_reset();
    ir_valid = 9'h0A2;
    @(posedge clock);
    #1;
    chk("stall_grant_id",    32'(irq_id),   32'd1);
    chk("stall_grant_ready", 32'(ir_ready), 32'h002);
    ir_valid = 9'h0A0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      chk($sformatf("stall_id%0d", i),    32'(irq_id),    32'd1);
      chk($sformatf("stall_ready%0d", i), 32'(ir_ready),  32'd0);
      chk($sformatf("stall_valid%0d", i), 32'(irq_valid), 32'd1);
    end
    irq_ready = 1'b1;
    @(posedge clock);
    #1;
    irq_ready = 1'b0;
    chk("stall_ack_valid", 32'(irq_valid), 32'd0);
    chk("stall_ack_count", 32'(irq_count), 32'd1);
    @(posedge clock);
    #1;
    chk("stall_next_valid", 32'(irq_valid), 32'd1);
    chk("stall_next_id",    32'(irq_id),    32'd5);
    chk("stall_next_ready", 32'(ir_ready),  32'h020);

    // Group source vs pin 0 from ptr=0.
    do_reset();
`ifdef GPIO_IRQ_GROUP_PRIO_EN
    grp_exp = '{4'd8, 4'd0};
`else
    grp_exp = '{4'd0, 4'd8};
`endif
    collect(9'h101, 1'b0, 2);
    chk("group_first",  32'(got_ids[0]), 32'(grp_exp[0]));
    chk("group_second", 32'(got_ids[1]), 32'(grp_exp[1]));

    // Counter wrap on the 4-bit instance: one handshake every 2 cycles.
    do_reset();
    w_ir_valid = 9'h001;
    repeat (30) @(posedge clock);
    #1;
    chk("wrap_count15", 32'(w_irq_count), 32'd15);
    repeat (2) @(posedge clock);
    #1;
    chk("wrap_count0",  32'(w_irq_count), 32'd0);
    w_ir_valid = 9'h000;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
